// File: rtl/stream_mux.sv
// N-channel stream multiplexer with a single registered output stage.
// Channel choice is either a fixed index (mode 0) or round-robin arbitration (mode 1).
module stream_mux #(
  parameter int unsigned  WIDTH = 20,
  parameter int unsigned  N     = 4,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  out_chan_q;
  logic [SELW-1:0]  ptr_q;

  logic             load_en;
  logic             gnt_any;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !out_valid_q || out_ready;

  // At most one grant; round-robin searches upward from ptr_q with wrap.
  always_comb begin
    int unsigned c;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
          gnt_idx  = SELW'(i);
          gnt_any  = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        c = 32'(ptr_q) + k;
        if (c >= N) c = c - N;
        if (!gnt_any && in_valid[c]) begin
          grant[c] = 1'b1;
          gnt_idx  = SELW'(c);
          gnt_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates in_ready so no handshake is seen while reset is held.
  assign in_ready = (rst_n && load_en) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else if (load_en) begin
      if (gnt_any) begin
        out_data_q  <= gnt_data;
        out_chan_q  <= gnt_idx;
        out_valid_q <= 1'b1;
        if (mode) ptr_q <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: directed scenarios plus randomized traffic against a
// transaction-level reference model; a second N=3 instance covers out-of-range sel.
module tb_stream_mux;

  localparam int W = 20;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_chan;

  logic           mode3;
  logic [1:0]     sel3;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3;
  logic [1:0]     out_chan3;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit         m_valid;
  bit [W-1:0] m_data;
  int         m_chan;
  int         m_ptr;

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  stream_mux #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int g = -1;
    if (!m_valid || out_ready) begin
      if (mode == 1'b0) begin
        if (in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
    end
    return g;
  endfunction

  // Called at posedge+1 with inputs already driven; advances one clock.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_chan  = g;
        if (mode) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_chan", 64'(out_chan), 64'(m_chan));
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    in_valid  = '1;
    in_valid3 = '1;
    rst_n     = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_chan", 64'(out_chan), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid  = '0;
    in_valid3 = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  initial begin
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check("post-rst out_valid", 64'(out_valid), 64'd0);

    // Fixed select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, W'(20'h11111 * (i + 1)));
    set_ch(2, 20'hABCDE);
    #1;
    check("fixed in_ready", 64'(in_ready), 64'b0100);
    cycle();
    check("fixed data", 64'(out_data), 64'hABCDE);
    check("fixed chan", 64'(out_chan), 64'd2);

    // Round-robin fairness from fresh reset
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr seq", 64'(out_chan), 64'(seq[i]));
    end

    // Wrap/skip: get ptr to 3, then single ch1, then ch0|ch3
    in_valid = 4'b0100; cycle();
    in_valid = 4'b0010; cycle();
    check("skip chan", 64'(out_chan), 64'd1);
    in_valid = 4'b1001; cycle();
    check("wrap chan", 64'(out_chan), 64'd3);
    in_valid = 4'b1111; cycle();
    check("wrap ptr0", 64'(out_chan), 64'd0);

    // Backpressure
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_ch(0, 20'h12345); cycle();
    out_ready = 1'b0; in_valid = 4'b1111; set_ch(0, 20'h55555);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall data", 64'(out_data), 64'h12345);
      check("stall rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; cycle();
    check("unstall valid", 64'(out_valid), 64'd1);
    check("unstall data", 64'(out_data), 64'h55555);
    in_valid = 4'b0000; cycle();
    check("drain valid", 64'(out_valid), 64'd0);

    // Async reset mid-stream with a word held
    mode = 1'b1; in_valid = 4'b0100; cycle();
    do_reset();
    mode = 1'b1; in_valid = 4'b1110; cycle();
    in_valid = 4'b1111; cycle();
    check("rst ptr start", 64'(out_chan), 64'd2);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_ch(i, W'($urandom));
      cycle();
    end

    // Out-of-range sel on the 3-channel instance
    do_reset();
    mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {20'h33333, 20'h22222, 20'h11111};
    #1;
    check("n3 in_ready", 64'(in_ready3), 64'b010);
    @(posedge clk);
    #1;
    check("n3 load valid", 64'(out_valid3), 64'd1);
    check("n3 load data", 64'(out_data3), 64'h22222);
    sel3 = 2'd3;
    #1;
    check("n3 bad sel rdy", 64'(in_ready3), 64'd0);
    @(posedge clk);
    #1;
    check("n3 drained", 64'(out_valid3), 64'd0);
    check("n3 hold data", 64'(out_data3), 64'h22222);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001: Parameter WIDTH, default 20, data width per channel in bits.
REQ-002: Parameter N, default 4, number of input channels (N >= 2); SELW = clog2(N) is derived, not overridable.
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: mode  input  1  0 = fixed select by sel, 1 = round-robin arbitration.
REQ-006: sel  input  SELW  channel index used when mode = 0.
REQ-007: in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008: in_valid  input  N  per-channel data valid.
REQ-009: in_ready  output  N  per-channel accept; combinational.
REQ-010: out_data  output  WIDTH  registered selected word.
REQ-011: out_valid  output  1  out_data/out_chan hold a word.
REQ-012: out_ready  input  1  downstream accept.
REQ-013: out_chan  output  SELW  source channel index of held word.

Function
REQ-014: Single registered output stage; input-to-output latency exactly 1 cycle.
REQ-015: load_en = !out_valid || out_ready; full throughput (one word per cycle) with out_ready held high.
REQ-016: At most one grant per cycle; in_ready[i] = load_en && grant[i]; transfer on channel i when in_valid[i] && in_ready[i].
REQ-017: mode 0: grant[sel] = in_valid[sel]; sel >= N grants nothing; other channels never granted.
REQ-018: mode 1: grant first channel with in_valid set, searching ptr, ptr+1, ... wrapping N-1 to 0.
REQ-019: ptr is a SELW-bit register; on mode-1 transfer from channel g, ptr <= (g == N-1) ? 0 : g+1; unchanged otherwise, including all mode-0 cycles.
REQ-020: On transfer: out_data <= in_data of granted channel, out_chan <= g, out_valid <= 1.
REQ-021: Output drained without new transfer (out_valid && out_ready, no grant): out_valid <= 0; out_data/out_chan hold last value.
REQ-022: Stall (out_valid && !out_ready): out_data, out_chan, out_valid, ptr unchanged; all in_ready = 0.
REQ-023: Simultaneous drain and load in one cycle: new word replaces old; no bubble.
REQ-024: mode/sel changes take effect on the current cycle's grant only; held word unaffected.
REQ-025: No combinational path from out_ready or in_valid to out_data/out_valid; in_ready may depend combinationally on out_ready, in_valid, mode, sel, ptr.
REQ-026: in_data of non-granted channels never affects state.

Reset
REQ-027: rst_n low asynchronously forces out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
REQ-028: Reset mid-operation discards any held word; no transfer counted in the reset cycle; in_ready = 0 while reset asserted.
REQ-029: First grant after reset release in mode 1 starts search at channel 0.

Verification
REQ-030: Fixed select: N=4, mode=0, sel=2, in_valid=4'b1111, ch2=20'hABCDE, out_ready=1 -> in_ready=4'b0100; next cycle out_data=20'hABCDE, out_chan=2, out_valid=1.
REQ-031: Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-032: Wrap/skip: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2; then in_valid=4'b1001 -> grant ch3, ptr wraps to 0.
REQ-033: Backpressure: out_valid=1 holding 20'h12345, out_ready=0 for 3 cycles with all in_valid high -> out_data stays 20'h12345, in_ready=0; out_ready=1 -> new word next cycle, no gap.
REQ-034: Invalid sel: N=3, mode=0, sel=3, all in_valid high -> in_ready=0, out_valid falls to 0 after draining.
REQ-035: Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> out_valid=0, out_data=0, ptr=0 immediately, before next edge.
